// File: rtl/conv_seq.sv
// Sequencer for the time-multiplexed 3x3 multiply-sum datapath: latches a window/kernel pair,
// steps the datapath through three passes, accumulates the partial sums and hands the result downstream.
module conv_seq #(
    parameter int unsigned SUM_W = 16,
    parameter int unsigned ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [71:0]      in_img,
    input  logic [71:0]      in_krn,
    output logic [71:0]      img_q,
    output logic [71:0]      krn_q,
    output logic [1:0]       select,
    input  logic [SUM_W-1:0] sum_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             busy
);

    localparam int unsigned PC_W   = 2;
    localparam int unsigned DATA_W = 72;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [PC_W-1:0]    pc, pc_d;
    logic [ACC_W-1:0]   acc, acc_d;
    logic [ACC_W-1:0]   result_d;
    logic [DATA_W-1:0]  img_d, krn_d;
    logic               out_valid_d;
    logic               accept;
    logic [ACC_W-1:0]   sum_ext;

    // Handshake and datapath control are decoded straight from the state register.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign select   = (state == RUN) ? pc : 2'd0;
    assign busy     = (state != IDLE);
    assign sum_ext  = ACC_W'(sum_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            acc       <= '0;
            result    <= '0;
            img_q     <= '0;
            krn_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            acc       <= acc_d;
            result    <= result_d;
            img_q     <= img_d;
            krn_q     <= krn_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state logic; a DONE handoff with a waiting pair goes straight back to RUN.
    always_comb begin
        state_d     = state;
        pc_d        = pc;
        acc_d       = acc;
        result_d    = result;
        img_d       = img_q;
        krn_d       = krn_q;
        out_valid_d = out_valid;

        case (state)
            IDLE: begin
                if (accept) begin
                    img_d   = in_img;
                    krn_d   = in_krn;
                    acc_d   = '0;
                    pc_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pc == 2'd2) begin
                    result_d    = acc + sum_ext;
                    out_valid_d = 1'b1;
                    pc_d        = '0;
                    state_d     = DONE;
                end else begin
                    acc_d = acc + sum_ext;
                    pc_d  = PC_W'(pc + 2'd1);
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        img_d   = in_img;
                        krn_d   = in_krn;
                        acc_d   = '0;
                        pc_d    = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                pc_d        = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_seq.sv
// Bench for conv_seq with a behavioural multiply-sum datapath; pass s sums products of pixels 3s..3s+2.
module tb_conv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_img;
    logic [71:0] in_krn;
    logic [71:0] img_q;
    logic [71:0] krn_q;
    logic [1:0]  select;
    logic [15:0] sum_in;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] result;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [71:0] img;
        logic [71:0] krn;
        logic [19:0] exp_result;
    } vec_t;

    vec_t vecs[6];

    conv_seq #(.SUM_W(16), .ACC_W(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_img    (in_img),
        .in_krn    (in_krn),
        .img_q     (img_q),
        .krn_q     (krn_q),
        .select    (select),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Datapath model: 16-bit wrapping sum of three 8x8 products for the selected pass.
    logic [31:0] comp_acc;
    always_comb begin
        comp_acc = '0;
        for (int j = 0; j < 3; j++) begin
            if (int'(select) * 3 + j < 9)
                comp_acc = comp_acc
                    + 32'(img_q[8*(int'(select)*3+j) +: 8]) * 32'(krn_q[8*(int'(select)*3+j) +: 8]);
        end
    end
    assign sum_in = comp_acc[15:0];

    function automatic logic [71:0] seq9(input int start, input int step);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[8*i +: 8] = 8'(start + step * i);
        return v;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE with out_ready high, checking each cycle.
    task automatic run_vec(input int idx);
        in_img    = vecs[idx].img;
        in_krn    = vecs[idx].krn;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d idle in_ready", idx), 72'(in_ready), 72'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk($sformatf("v%0d img_q", idx), img_q, vecs[idx].img);
        chk($sformatf("v%0d krn_q", idx), krn_q, vecs[idx].krn);
        chk($sformatf("v%0d sel0", idx), {70'd0, select}, 72'd0);
        chk($sformatf("v%0d run in_ready", idx), {in_ready, out_valid, busy}, {69'd0, 3'b001});
        tick();
        chk($sformatf("v%0d sel1", idx), {in_ready, out_valid, select}, {68'd0, 4'b0001});
        tick();
        chk($sformatf("v%0d sel2", idx), {in_ready, out_valid, select}, {68'd0, 4'b0010});
        tick();
        chk($sformatf("v%0d valid", idx), {out_valid, select}, {69'd0, 3'b100});
        chk($sformatf("v%0d result", idx), 72'(result), 72'(vecs[idx].exp_result));
        tick();
        chk($sformatf("v%0d back idle", idx), {out_valid, busy}, 72'd0);
    endtask

    initial begin
        vecs[0] = '{seq9(1, 0),   seq9(1, 0),  20'd9};
        vecs[1] = '{seq9(1, 1),   seq9(9, -1), 20'd165};
        vecs[2] = '{seq9(255, 0), seq9(255, 0), 20'd192009};
        vecs[3] = '{seq9(1, 1),   seq9(1, 0),  20'd45};
        vecs[4] = '{seq9(10, 10), seq9(2, 0),  20'd900};
        vecs[5] = '{seq9(0, 0),   seq9(77, 3), 20'd0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_img = '0; in_krn = '0;
        tick();
        tick();
        chk("reset outs", {out_valid, busy, select}, 72'd0);
        chk("reset result", 72'(result), 72'd0);
        chk("reset img_q", img_q, 72'd0);
        chk("reset krn_q", krn_q, 72'd0);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", 72'(in_ready), 72'd1);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Backpressure hold, then same-cycle handoff to a new pair.
        in_img = seq9(1, 1); in_krn = seq9(9, -1); in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("hold start valid", {out_valid, 20'(result)}, {51'd0, 1'b1, 20'd165});
        in_img = seq9(1, 1); in_krn = seq9(1, 0); in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold c%0d", i), {in_ready, out_valid, select, 20'(result)},
                {48'd0, 1'b0, 1'b1, 2'd0, 20'd165});
            chk($sformatf("hold img c%0d", i), img_q, seq9(1, 1));
        end
        chk("hold krn", krn_q, seq9(9, -1));
        out_ready = 1'b1;
        #1;
        chk("handoff in_ready", 72'(in_ready), 72'd1);
        tick();
        in_valid = 1'b0;
        chk("handoff run", {out_valid, busy, select}, {68'd0, 4'b0100});
        chk("handoff krn", krn_q, seq9(1, 0));
        tick(); tick(); tick();
        chk("handoff result", {out_valid, 20'(result)}, {51'd0, 1'b1, 20'd45});
        tick();
        chk("handoff idle", 72'(busy), 72'd0);

        // Reset mid-run discards the window.
        in_img = seq9(255, 0); in_krn = seq9(255, 0); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre-reset sel1", {70'd0, select}, 72'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid reset", {in_ready, out_valid, busy, select, 20'(result)},
            {47'd0, 5'b10000, 20'd0});
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                seen |= out_valid;
            end
            chk("no stale result", 72'(seen), 72'd0);
        end

        // Reset coinciding with an accept wins.
        in_valid = 1'b1; rst_n = 1'b0;
        tick();
        chk("reset vs accept", {img_q[7:0], busy}, 72'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();

        // Continuous streaming: one result every four cycles.
        in_img = seq9(1, 1); in_krn = seq9(9, -1); in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("stream c%0d", i), {out_valid, select},
                {69'd0, (i % 4 == 3), 2'((i % 4 == 3) ? 0 : i % 4)});
            if (i % 4 == 3) chk($sformatf("stream res c%0d", i), 72'(result), 72'd165);
        end
        in_valid = 1'b0;
        tick();
        chk("stream end", {out_valid, busy}, 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
